// File: rtl/wrp_shff_din_nch.sv
// rtl/wrp_shff_din_nch.sv - multi-channel AXI-S input wrapper issuing lock-step block bursts
module wrp_shff_din_nch #(
  parameter int NCH     = 16,
  parameter int DW      = 64,
  parameter int DEPTH   = 64,
  parameter int BLK_LEN = 16,
  parameter int RD_LAT  = 2,
  parameter int NRDY    = 16,
  parameter int SKEW_TO = 4096
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic [NCH-1:0]    s_tvalid_i,
  output logic [NCH-1:0]    s_tready_o,
  input  logic [NCH*DW-1:0] s_tdata_i,
  input  logic [NRDY-1:0]   rdy_i,
  input  logic              flush_i,
  output logic              start_o,
  output logic              vld_o,
  output logic [NCH*DW-1:0] y_o,
  output logic              err_skew_o,
  output logic [15:0]       blk_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BLK_LEN);
  localparam int SW = $clog2(SKEW_TO) + 1;

  typedef enum logic {S_WAIT, S_RD} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    rd_cnt, rd_cnt_nxt;
  logic             rdy_q, flush_pend, flush_app, go, pop, skewed;
  logic [NCH-1:0]   has_blk, push, tready_q;
  logic [SW-1:0]    skew_cnt;
  logic [NCH*DW-1:0] rd_word;
  logic [NCH*DW-1:0] d [RD_LAT];
  logic [RD_LAT-1:0] v, st;

  // A pending flush takes effect in the first idle cycle so a running burst is never cut.
  assign flush_app = (state == S_WAIT) & (flush_i | flush_pend);
  assign go        = (&has_blk) & rdy_q;
  assign pop       = (state == S_RD);
  assign skewed    = (state == S_WAIT) & (|has_blk) & ~(&has_blk);
  assign s_tready_o = tready_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] lvl, lvl_nxt;

    assign push[c]    = s_tvalid_i[c] & tready_q[c] & ~flush_app;
    assign has_blk[c] = (lvl >= LW'(BLK_LEN));
    assign lvl_nxt    = lvl + LW'(push[c]) - LW'(pop);
    assign rd_word[c*DW +: DW] = mem[rp];

    always_ff @(posedge clk) begin
      if (push[c]) mem[wp] <= s_tdata_i[c*DW +: DW];
    end

    // Ready is registered from the next level, so it is low at full regardless of a same-cycle pop.
    always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
        lvl         <= '0;
        wp          <= '0;
        rp          <= '0;
        tready_q[c] <= 1'b0;
      end else if (flush_app) begin
        lvl         <= '0;
        wp          <= '0;
        rp          <= '0;
        tready_q[c] <= 1'b1;
      end else begin
        lvl         <= lvl_nxt;
        wp          <= wp + AW'(push[c]);
        rp          <= rp + AW'(pop);
        tready_q[c] <= (lvl_nxt != LW'(DEPTH));
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    case (state)
      S_WAIT: begin
        if (go && !flush_app) begin
          state_nxt  = S_RD;
          rd_cnt_nxt = '0;
        end
      end
      S_RD: begin
        rd_cnt_nxt = rd_cnt + 1'b1;
        if (rd_cnt == CW'(BLK_LEN - 1)) state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_WAIT;
      rd_cnt     <= '0;
      rdy_q      <= 1'b0;
      flush_pend <= 1'b0;
      skew_cnt   <= '0;
      err_skew_o <= 1'b0;
      blk_cnt_o  <= '0;
    end else begin
      state  <= state_nxt;
      rd_cnt <= rd_cnt_nxt;
      rdy_q  <= &rdy_i;
      if (state == S_WAIT) flush_pend <= 1'b0;
      else if (flush_i)    flush_pend <= 1'b1;
      if (flush_app) begin
        skew_cnt   <= '0;
        err_skew_o <= 1'b0;
      end else if (skewed) begin
        if (skew_cnt == SW'(SKEW_TO - 1)) err_skew_o <= 1'b1;
        else                              skew_cnt   <= skew_cnt + 1'b1;
      end else begin
        skew_cnt <= '0;
      end
      if (start_o) blk_cnt_o <= blk_cnt_o + 16'd1;
    end
  end

  // Data stages only advance with their valid bit, so y_o holds between bursts.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      v  <= '0;
      st <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0]  <= pop;
      st[0] <= pop & (rd_cnt == '0);
      if (pop) d[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i]  <= v[i-1];
        st[i] <= st[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign vld_o   = v[RD_LAT-1];
  assign start_o = st[RD_LAT-1];
  assign y_o     = d[RD_LAT-1];

endmodule

// File: tb/tb_wrp_shff_din_nch.sv
// tb/tb_wrp_shff_din_nch.sv - directed self-checking bench for wrp_shff_din_nch
module tb_wrp_shff_din_nch;

  localparam int NCH = 16, DW = 64, DEPTH = 64, BLK_LEN = 16, RD_LAT = 2, NRDY = 16, SKEW_TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    s_tvalid, s_tready;
  logic [NCH*DW-1:0] s_tdata, y;
  logic [NRDY-1:0]   rdy;
  logic              flush, start, vld, err;
  logic [15:0]       blk_cnt;
  int                total = 0, bad = 0;

  always #5 clk = ~clk;

  wrp_shff_din_nch #(
    .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .BLK_LEN(BLK_LEN),
    .RD_LAT(RD_LAT), .NRDY(NRDY), .SKEW_TO(SKEW_TO)
  ) dut (
    .clk(clk), .rst_i(rst),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata),
    .rdy_i(rdy), .flush_i(flush),
    .start_o(start), .vld_o(vld), .y_o(y),
    .err_skew_o(err), .blk_cnt_o(blk_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lane(input int c);
    return y[c*DW +: DW];
  endfunction

  function automatic logic [63:0] word(input int c, input int w);
    return 64'((c << 8) | w);
  endfunction

  task automatic push(input int n, input logic [NCH-1:0] mask, input int base);
    for (int i = 0; i < n; i++) begin
      s_tvalid = mask;
      for (int c = 0; c < NCH; c++) s_tdata[c*DW +: DW] = word(c, base + i);
      tick;
    end
    s_tvalid = '0;
  endtask

  // mode 1: drop rdy mid-burst, mode 2: pulse flush mid-burst
  task automatic burst(input string tag, input int base, input int mode, output int lat);
    lat = 0;
    while (vld !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
    chk({tag, "_seen"}, 64'(vld), 64'(1));
    if (vld !== 1'b1) return;
    for (int i = 0; i < BLK_LEN; i++) begin
      chk({tag, "_vld"}, 64'(vld), 64'(1));
      chk({tag, "_start"}, 64'(start), 64'(i == 0));
      for (int c = 0; c < NCH; c++) chk({tag, "_lane"}, lane(c), word(c, base + i));
      if (mode == 1 && i == 4) rdy = '0;
      if (mode == 2) flush = (i == 4);
      tick;
    end
    flush = 1'b0;
    chk({tag, "_end"}, 64'(vld), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt;
    rst = 1'b1; s_tvalid = '0; s_tdata = '0; rdy = '1; flush = 1'b0;
    tick; tick;
    chk("rst_tready", 64'(s_tready), 64'(0));
    chk("rst_vld", 64'(vld), 64'(0));
    chk("rst_start", 64'(start), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_blk", 64'(blk_cnt), 64'(0));
    chk("rst_y", lane(0), 64'(0));
    rst = 1'b0;
    tick;
    chk("rel_tready", 64'(s_tready), 64'hFFFF);

    // basic burst; latency counted from the cycle after the last push
    push(BLK_LEN, '1, 0);
    burst("basic", 0, 0, lat);
    chk("basic_lat", 64'(lat), 64'(RD_LAT + 1));
    chk("basic_blk", 64'(blk_cnt), 64'(1));
    chk("basic_hold", lane(3), word(3, 15));
    for (int k = 0; k < 3; k++) begin tick; chk("basic_idle", 64'(vld), 64'(0)); end

    // back-pressure
    rdy = '1; rdy[5] = 1'b0;
    push(BLK_LEN, '1, 16);
    for (int k = 0; k < 6; k++) begin tick; chk("bp_nostart", 64'(vld | start), 64'(0)); end
    rdy = '1;
    burst("bp", 16, 1, lat);
    chk("bp_lat", 64'(lat), 64'(2 + RD_LAT));
    chk("bp_blk", 64'(blk_cnt), 64'(2));
    rdy = '1;

    // full FIFOs with stalled downstream
    rdy = '0;
    cnt = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      s_tvalid = '1;
      for (int c = 0; c < NCH; c++) s_tdata[c*DW +: DW] = word(c, i);
      if (s_tready[0]) cnt++;
      tick;
    end
    s_tvalid = '0;
    chk("full_cnt", 64'(cnt), 64'(DEPTH));
    chk("full_tready", 64'(s_tready), 64'(0));
    rdy = '1;
    burst("full0", 0, 0, lat);
    burst("full1", 16, 0, lat);
    burst("full2", 32, 0, lat);
    burst("full3", 48, 0, lat);
    chk("full_tready_after", 64'(s_tready), 64'hFFFF);
    chk("full_blk", 64'(blk_cnt), 64'(6));

    // skew watchdog
    push(BLK_LEN, 16'h0001, 0);
    for (int k = 0; k < SKEW_TO - 1; k++) tick;
    chk("skew_early", 64'(err), 64'(0));
    tick;
    chk("skew_set", 64'(err), 64'(1));
    push(BLK_LEN, 16'hFFFE, 0);
    burst("skew", 0, 0, lat);
    chk("skew_sticky", 64'(err), 64'(1));
    chk("skew_blk", 64'(blk_cnt), 64'(7));

    // flush during a burst; second buffered block must vanish
    rdy = '0;
    push(2 * BLK_LEN, '1, 0);
    rdy = '1;
    burst("flush", 0, 2, lat);
    for (int k = 0; k < 5; k++) begin tick; chk("flush_idle", 64'(vld), 64'(0)); end
    chk("flush_err", 64'(err), 64'(0));
    chk("flush_tready", 64'(s_tready), 64'hFFFF);
    chk("flush_blk", 64'(blk_cnt), 64'(8));
    push(BLK_LEN, '1, 32);
    burst("post_flush", 32, 0, lat);
    chk("post_flush_blk", 64'(blk_cnt), 64'(9));

    // async reset mid-burst
    push(BLK_LEN, 16'h0001, 0);
    for (int k = 0; k < SKEW_TO; k++) tick;
    chk("pre_rst_err", 64'(err), 64'(1));
    push(BLK_LEN, 16'hFFFE, 0);
    lat = 0;
    while (vld !== 1'b1 && lat < 100) begin tick; lat++; end
    tick; tick; tick;
    chk("mid_vld", 64'(vld), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 64'(vld), 64'(0));
    chk("arst_start", 64'(start), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_blk", 64'(blk_cnt), 64'(0));
    chk("arst_y", lane(1), 64'(0));
    chk("arst_tready", 64'(s_tready), 64'(0));
    tick; tick;
    rst = 1'b0;
    tick;
    chk("arst_rel_tready", 64'(s_tready), 64'hFFFF);
    push(BLK_LEN, '1, 8'h40);
    burst("post_rst", 8'h40, 0, lat);
    chk("post_rst_blk", 64'(blk_cnt), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
